// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: FSM encodings and default geometry for rom_stream_reader and its bench
package rom_stream_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks an external ROM over a (base, len) burst and emits a valid/ready stream
// ROM_STREAM_CHECKSUM_EN adds a csum output: XOR of every transferred word of the burst
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);
  logic [1:0]      state;
  logic [ADDR_W:0] rem;
  logic            accept;
  logic            one_left;
  assign accept   = state == ST_IDLE && cmd_start && !abort;
  assign one_left = rem == (ADDR_W+1)'(1);
  assign done     = state == ST_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rem       <= '0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && cmd_len == '0) state <= ST_DONE;
          else if (accept) begin
            rom_addr <= cmd_base;
            rem      <= cmd_len;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN, ST_LAST: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (state == ST_LAST && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end else if (state == ST_RUN && (!out_valid || out_ready)) begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
            out_last  <= one_left;
            rom_addr  <= rom_addr + 1'b1;
            rem       <= rem - 1'b1;
            state     <= one_left ? ST_LAST : ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef ROM_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum <= '0;
    else if (accept) csum <= '0;
    else if (out_valid && out_ready) csum <= csum ^ out_data;
  end
`endif
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: randomized bursts against a queue-based model of the expected stream
module tb_rom_stream_reader;
  import rom_stream_pkg::*;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, rst_n = 1'b0, cmd_start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] cmd_base = '0, rom_addr;
  logic [AW:0] cmd_len = '0;
  logic [DW-1:0] rom_data, out_data;
  logic out_valid, out_last, busy, done;
  logic [DW-1:0] rom [DEPTH];
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif
  int n_pass = 0, n_total = 0;
  rom_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef ROM_STREAM_CHECKSUM_EN
    , .csum(csum)
`endif
  );
  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic burst(input int base, input int len, input int ready_pct, input int stall_at, input bit poke);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] x, held_d, ref_word;
    logic [AW-1:0] held_a;
    bit stalled;
    int beats, first_v, last_hs, done_cyc, n_done, stall_cnt;
    logic [DW-1:0] csum_at_done;
    x = '0; stalled = 0; beats = 0; first_v = -1; last_hs = -1; done_cyc = -1;
    n_done = 0; stall_cnt = 0; csum_at_done = '0; held_d = '0; held_a = '0;
    for (int i = 0; i < len; i++) exp_q.push_back(rom[(base + i) % DEPTH]);
    @(negedge clk);
    cmd_base = AW'(base); cmd_len = (AW+1)'(len); cmd_start = 1'b1;
    out_ready = ($urandom_range(99) < ready_pct);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (poke && c == 3) begin
        cmd_start = 1'b1; cmd_base = AW'($urandom); cmd_len = (AW+1)'(DEPTH);
      end
      if (stall_at >= 0 && beats == stall_at && out_valid && stall_cnt < 3) begin
        out_ready = 1'b0; stall_cnt++;
      end else out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (stalled) begin
        check("hold_data", out_data, held_d);
        check("hold_addr", rom_addr, held_a);
      end
      if (out_valid && first_v < 0) first_v = c;
      if (done) begin
        n_done++; done_cyc = c;
`ifdef ROM_STREAM_CHECKSUM_EN
        csum_at_done = csum;
`endif
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          ref_word = exp_q.pop_front();
          check("data", out_data, ref_word);
          check("last", out_last, exp_q.size() == 0);
        end
        x ^= out_data; beats++; last_hs = c;
      end
      stalled = out_valid && !out_ready; held_d = out_data; held_a = rom_addr;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    cmd_start = 1'b0;
    check("beats", beats, len);
    check("done_count", n_done, 1);
    check("busy_end", busy, 0);
    if (len > 0) begin
      check("latency", first_v, 2);
      check("done_timing", done_cyc, last_hs + 1);
      if (ready_pct == 100 && stall_at < 0) check("throughput", last_hs - first_v, len - 1);
    end else check("no_valid", first_v, -1);
`ifdef ROM_STREAM_CHECKSUM_EN
    check("csum", csum_at_done, x);
`endif
  endtask
  initial begin
    bit bad;
    int hs;
    for (int i = 0; i < DEPTH; i++) rom[i] = DW'((i << 5) | $urandom_range(31));
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_data", out_data, 0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (5) begin @(negedge clk); #1; bad |= out_valid | busy | done; end
    check("idle_quiet", bad, 0);
    burst(0, 8, 100, -1, 0);
    burst(6, 4, 100, -1, 0);
    burst(2, 5, 100, 1, 0);
    burst(0, 0, 100, -1, 0);
    burst(3, 8, 100, -1, 1);
    for (int k = 0; k < 10; k++) burst($urandom_range(DEPTH - 1), $urandom_range(1, DEPTH), 60, -1, k[0]);
    // abort after the third transferred word of an 8-word burst
    @(negedge clk); cmd_base = '0; cmd_len = (AW+1)'(8); cmd_start = 1'b1; out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      @(negedge clk); cmd_start = 1'b0; #1;
      if (out_valid && out_ready) hs++;
    end
    check("abort_reach", hs, 3);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_last", out_last, 0);
    bad = 0;
    repeat (5) begin @(negedge clk); #1; bad |= done | out_valid; end
    check("abort_no_done", bad, 0);
    // abort together with a start in IDLE drops the command
    @(negedge clk); cmd_start = 1'b1; abort = 1'b1; cmd_len = (AW+1)'(4);
    @(negedge clk); cmd_start = 1'b0; abort = 1'b0;
    bad = 0;
    repeat (4) begin #1; bad |= busy | out_valid | done; @(negedge clk); end
    check("abort_start_dropped", bad, 0);
    // asynchronous reset mid-burst clears outputs immediately
    cmd_base = '0; cmd_len = (AW+1)'(8); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    repeat (3) @(negedge clk);
    #1; check("pre_rst_busy", busy, 1);
    rst_n = 1'b0; #1;
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    burst(5, 3, 100, -1, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
